// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and constant helpers for the banked frame buffer
package fb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    localparam int FB_FRAMES = 2;

    // First pixel address held by bank idx; used as a constant decode threshold.
    function automatic longint bank_base(input int idx, input int depth);
        return longint'(idx) * longint'(depth);
    endfunction

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_bank.sv
// rtl/fb_bank.sv - one physical bank: inferred RAM or vendor macro, plus optional output stage
module fb_bank #(
    parameter int DATA_W     = 4,
    parameter int BANK_DEPTH = 128000,
    parameter int BANK_AW    = 17,
    parameter int RD_LAT     = 1,
    parameter int SIM        = 0
) (
    input  logic               clk,
    input  logic               we,
    input  logic [BANK_AW-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [BANK_AW-1:0] raddr,
    output logic [DATA_W-1:0]  rdata,
    output logic               ready
);

    logic [DATA_W-1:0] core_q;

    if (SIM != 0) begin : g_inferred
        logic [DATA_W-1:0] mem [BANK_DEPTH];

        always_ff @(posedge clk) begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            core_q <= mem[raddr];
        end

        assign ready = 1'b1;
    end else begin : g_macro
        fb_lram_macro #(
            .DATA_W    (DATA_W),
            .BANK_DEPTH(BANK_DEPTH),
            .BANK_AW   (BANK_AW)
        ) u_macro (
            .clk  (clk),
            .we   (we),
            .waddr(waddr),
            .wdata(wdata),
            .raddr(raddr),
            .rdata(core_q),
            .ready(ready)
        );
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] q2;

        always_ff @(posedge clk) begin
            q2 <= core_q;
        end

        assign rdata = q2;
    end else begin : g_lat1
        assign rdata = core_q;
    end

endmodule

// File: rtl/fb_bank_decode.sv
// rtl/fb_bank_decode.sv - pixel address to bank index, bank offset and range flag
module fb_bank_decode
    import fb_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int BANK_DEPTH = 128000,
    parameter int BANK_AW    = 17,
    parameter int NUM_BANKS  = 2
) (
    input  logic [ADDR_W-1:0]               addr,
    output logic [sel_width(NUM_BANKS)-1:0] bank,
    output logic [BANK_AW-1:0]              offset,
    output logic                            in_range
);

    localparam int AW1   = ADDR_W + 1;
    localparam int SEL_W = sel_width(NUM_BANKS);

    logic [AW1-1:0] addr_x;
    logic [AW1-1:0] base;

    assign addr_x = {1'b0, addr};

    // Compare chain against constant thresholds; the last match wins.
    always_comb begin
        bank = '0;
        base = '0;
        for (int i = 1; i < NUM_BANKS; i++) begin
            if (addr_x >= AW1'(bank_base(i, BANK_DEPTH))) begin
                bank = SEL_W'(i);
                base = AW1'(bank_base(i, BANK_DEPTH));
            end
        end
        offset   = BANK_AW'(addr_x - base);
        in_range = addr_x < AW1'(bank_base(NUM_BANKS, BANK_DEPTH));
    end

endmodule

// File: rtl/fb_lram_macro.sv
// rtl/fb_lram_macro.sv - behavioural model of the vendor large-RAM macro interface
module fb_lram_macro #(
    parameter int DATA_W     = 4,
    parameter int BANK_DEPTH = 128000,
    parameter int BANK_AW    = 17
) (
    input  logic               clk,
    input  logic               we,
    input  logic [BANK_AW-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [BANK_AW-1:0] raddr,
    output logic [DATA_W-1:0]  rdata,
    output logic               ready
);

    logic [DATA_W-1:0] mem [BANK_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

    // The macro reports ready once it has been clocked after power-up.
    always_ff @(posedge clk) begin
        ready <= 1'b1;
    end

endmodule

// File: rtl/banked_frame_buffer.sv
// rtl/banked_frame_buffer.sv - double-buffered banked pixel store with swap, clear and range checking
module banked_frame_buffer
    import fb_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int ADDR_W     = 18,
    parameter int BANK_DEPTH = 128000,
    parameter int BANK_AW    = 17,
    parameter int NUM_BANKS  = 2,
    parameter int RD_LAT     = 1,
    parameter int SIM        = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              swap_req,
    input  logic              frame_start,
    output logic              swap_ack,
    output logic              front_sel,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_val,
    output logic              busy,
    output logic              oob_err,
    input  logic              oob_clr,
    output logic              ready
);

    localparam int SEL_W       = sel_width(NUM_BANKS);
    localparam int TOTAL_BANKS = FB_FRAMES * NUM_BANKS;
    localparam logic [BANK_AW-1:0] CLR_LAST = BANK_AW'(BANK_DEPTH - 1);

    logic [SEL_W-1:0]   wr_bank, rd_bank;
    logic [BANK_AW-1:0] wr_off, rd_off;
    logic               wr_in, rd_in;

    fb_bank_decode #(
        .ADDR_W    (ADDR_W),
        .BANK_DEPTH(BANK_DEPTH),
        .BANK_AW   (BANK_AW),
        .NUM_BANKS (NUM_BANKS)
    ) u_wr_dec (
        .addr    (wr_addr),
        .bank    (wr_bank),
        .offset  (wr_off),
        .in_range(wr_in)
    );

    fb_bank_decode #(
        .ADDR_W    (ADDR_W),
        .BANK_DEPTH(BANK_DEPTH),
        .BANK_AW   (BANK_AW),
        .NUM_BANKS (NUM_BANKS)
    ) u_rd_dec (
        .addr    (rd_addr),
        .bank    (rd_bank),
        .offset  (rd_off),
        .in_range(rd_in)
    );

    fb_state_t          state;
    logic [BANK_AW-1:0] clr_cnt;
    logic [DATA_W-1:0]  clr_val_q;
    logic               swap_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            clr_val_q <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state     <= CLEAR;
                        clr_val_q <= clear_val;
                        clr_cnt   <= '0;
                        busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                        busy    <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A request arriving on the executing edge is absorbed by that swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_pend <= 1'b0;
            swap_ack  <= 1'b0;
            front_sel <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            if (frame_start && swap_pend && !busy) begin
                front_sel <= ~front_sel;
                swap_ack  <= 1'b1;
                swap_pend <= 1'b0;
            end else if (swap_req) begin
                swap_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_err <= 1'b0;
        end else if ((wr_en && !wr_in) || (rd_en && !rd_in)) begin
            oob_err <= 1'b1;
        end else if (oob_clr) begin
            oob_err <= 1'b0;
        end
    end

    // Read select travels with the request so the output mux ignores live inputs.
    logic [RD_LAT-1:0] p_vld, p_in, p_front;
    logic [SEL_W-1:0]  p_bank [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld   <= '0;
            p_in    <= '0;
            p_front <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                p_bank[s] <= '0;
            end
        end else begin
            p_vld[0]   <= rd_en;
            p_in[0]    <= rd_in;
            p_front[0] <= front_sel;
            p_bank[0]  <= rd_bank;
            for (int s = 1; s < RD_LAT; s++) begin
                p_vld[s]   <= p_vld[s-1];
                p_in[s]    <= p_in[s-1];
                p_front[s] <= p_front[s-1];
                p_bank[s]  <= p_bank[s-1];
            end
        end
    end

    assign rd_valid = p_vld[RD_LAT-1];

    logic               host_wr;
    logic               bank_we  [TOTAL_BANKS];
    logic [BANK_AW-1:0] bank_wa  [TOTAL_BANKS];
    logic [DATA_W-1:0]  bank_wd  [TOTAL_BANKS];
    logic [BANK_AW-1:0] bank_ra  [TOTAL_BANKS];
    logic [DATA_W-1:0]  bank_q   [TOTAL_BANKS];
    logic [TOTAL_BANKS-1:0] bank_rdy;
    logic [TOTAL_BANKS-1:0] bank_hit;

    assign host_wr = wr_en && wr_in && !busy;

    for (genvar p = 0; p < TOTAL_BANKS; p++) begin : g_bank
        localparam logic             FRAME     = (p >= NUM_BANKS);
        localparam logic [SEL_W-1:0] LOCAL_IDX = SEL_W'(p % NUM_BANKS);

        assign bank_we[p]  = (front_sel != FRAME) &&
                             (busy || (host_wr && wr_bank == LOCAL_IDX));
        assign bank_wa[p]  = busy ? clr_cnt : wr_off;
        assign bank_wd[p]  = busy ? clr_val_q : wr_data;
        assign bank_ra[p]  = (rd_en && rd_in && front_sel == FRAME && rd_bank == LOCAL_IDX)
                             ? rd_off : '0;
        assign bank_hit[p] = rd_valid && p_in[RD_LAT-1] &&
                             p_front[RD_LAT-1] == FRAME && p_bank[RD_LAT-1] == LOCAL_IDX;

        fb_bank #(
            .DATA_W    (DATA_W),
            .BANK_DEPTH(BANK_DEPTH),
            .BANK_AW   (BANK_AW),
            .RD_LAT    (RD_LAT),
            .SIM       (SIM)
        ) u_bank (
            .clk  (clk),
            .we   (bank_we[p]),
            .waddr(bank_wa[p]),
            .wdata(bank_wd[p]),
            .raddr(bank_ra[p]),
            .rdata(bank_q[p]),
            .ready(bank_rdy[p])
        );
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < TOTAL_BANKS; p++) begin
            if (bank_hit[p]) begin
                rd_data = bank_q[p];
            end
        end
    end

    assign ready = &bank_rdy;

endmodule

// File: tb/tb_banked_frame_buffer.sv
// tb/tb_banked_frame_buffer.sv - directed table-driven bench for banked_frame_buffer
module tb_banked_frame_buffer;

    localparam int DATA_W     = 4;
    localparam int ADDR_W     = 9;
    localparam int BANK_DEPTH = 100;
    localparam int BANK_AW    = 7;
    localparam int NUM_BANKS  = 2;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              swap_req;
    logic              frame_start;
    logic              swap_ack;
    logic              front_sel;
    logic              clear_req;
    logic [DATA_W-1:0] clear_val;
    logic              busy;
    logic              oob_err;
    logic              oob_clr;
    logic              ready;

    banked_frame_buffer #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BANK_DEPTH(BANK_DEPTH),
        .BANK_AW   (BANK_AW),
        .NUM_BANKS (NUM_BANKS),
        .RD_LAT    (1),
        .SIM       (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .swap_req   (swap_req),
        .frame_start(frame_start),
        .swap_ack   (swap_ack),
        .front_sel  (front_sel),
        .clear_req  (clear_req),
        .clear_val  (clear_val),
        .busy       (busy),
        .oob_err    (oob_err),
        .oob_clr    (oob_clr),
        .ready      (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_oob;
    } vec_t;

    vec_t vecs [7];
    int   n_cmp;
    int   n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                           output logic v);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        d     = rd_data;
        v     = rd_valid;
        rd_en = 1'b0;
    endtask

    task automatic step(input logic sr, input logic fs);
        swap_req    = sr;
        frame_start = fs;
        @(negedge clk);
        swap_req    = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic              v;
        int                cnt;
        logic              ack_seen;

        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{addr: 9'd99,  wdata: 4'hA, exp_rdata: 4'hA, exp_oob: 1'b0};
        vecs[1] = '{addr: 9'd100, wdata: 4'h5, exp_rdata: 4'h5, exp_oob: 1'b0};
        vecs[2] = '{addr: 9'd0,   wdata: 4'h1, exp_rdata: 4'h1, exp_oob: 1'b0};
        vecs[3] = '{addr: 9'd199, wdata: 4'hC, exp_rdata: 4'hC, exp_oob: 1'b0};
        vecs[4] = '{addr: 9'd50,  wdata: 4'h9, exp_rdata: 4'h9, exp_oob: 1'b0};
        vecs[5] = '{addr: 9'd150, wdata: 4'hE, exp_rdata: 4'hE, exp_oob: 1'b0};
        vecs[6] = '{addr: 9'd200, wdata: 4'hF, exp_rdata: 4'h0, exp_oob: 1'b1};

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; swap_req = 1'b0; frame_start = 1'b0;
        clear_req = 1'b0; clear_val = '0; oob_clr = 1'b0;

        repeat (2) @(negedge clk);
        check("reset rd_data", rd_data, 0);
        check("reset rd_valid", rd_valid, 0);
        check("reset swap_ack", swap_ack, 0);
        check("reset front_sel", front_sel, 0);
        check("reset busy", busy, 0);
        check("reset oob_err", oob_err, 0);
        check("ready", ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill the back frame, including the bank boundary and one out-of-range address.
        for (int i = 0; i < 7; i++) begin
            do_write(vecs[i].addr, vecs[i].wdata);
            check($sformatf("wr oob_err @%0d", vecs[i].addr), oob_err, vecs[i].exp_oob);
        end
        oob_clr = 1'b1;
        @(negedge clk);
        oob_clr = 1'b0;
        check("oob_clr", oob_err, 0);

        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        check("swap1 ack", swap_ack, 1);
        check("swap1 front", front_sel, 1);
        @(negedge clk);
        check("swap1 ack one-shot", swap_ack, 0);

        for (int i = 0; i < 7; i++) begin
            do_read(vecs[i].addr, d, v);
            check($sformatf("rd valid @%0d", vecs[i].addr), v, 1);
            check($sformatf("rd data @%0d", vecs[i].addr), d, vecs[i].exp_rdata);
            check($sformatf("rd oob_err @%0d", vecs[i].addr), oob_err, vecs[i].exp_oob);
        end
        @(negedge clk);
        check("rd_valid idle", rd_valid, 0);

        // oob set wins over oob_clr in the same cycle.
        oob_clr = 1'b1; rd_en = 1'b1; rd_addr = 9'd200;
        @(negedge clk);
        oob_clr = 1'b0; rd_en = 1'b0;
        check("oob set priority", oob_err, 1);
        oob_clr = 1'b1;
        @(negedge clk);
        oob_clr = 1'b0;
        check("oob cleared", oob_err, 0);

        // A read issued on the swapping edge completes from the old front frame.
        do_write(9'd99, 4'h2);
        step(1'b1, 1'b0);
        frame_start = 1'b1; rd_en = 1'b1; rd_addr = 9'd99;
        @(negedge clk);
        frame_start = 1'b0; rd_en = 1'b0;
        check("inflight swap ack", swap_ack, 1);
        check("inflight front", front_sel, 0);
        check("inflight valid", rd_valid, 1);
        check("inflight old data", rd_data, 4'hA);
        do_read(9'd99, d, v);
        check("new front data", d, 4'h2);

        // Swap handshake: idle frame_start, repeated request, same-cycle request.
        step(1'b0, 1'b1);
        check("idle frame_start ack", swap_ack, 0);
        check("idle frame_start front", front_sel, 0);
        step(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        step(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        step(1'b0, 1'b1);
        check("single swap ack", swap_ack, 1);
        check("single swap front", front_sel, 1);
        step(1'b0, 1'b0);
        check("single swap ack drop", swap_ack, 0);
        step(1'b0, 1'b1);
        check("no second swap ack", swap_ack, 0);
        check("no second swap front", front_sel, 1);
        step(1'b1, 1'b1);
        check("same-cycle req ack", swap_ack, 0);
        check("same-cycle req front", front_sel, 1);
        step(1'b0, 1'b1);
        check("deferred swap ack", swap_ack, 1);
        check("deferred swap front", front_sel, 0);

        // Clear the back frame; inject a dropped write, ignored clear and deferred swap.
        clear_req = 1'b1; clear_val = 4'h3;
        @(negedge clk);
        clear_req = 1'b0; clear_val = 4'h0;
        cnt = 0;
        ack_seen = 1'b0;
        while (busy && cnt < 1000) begin
            wr_en       = (cnt == 50);
            wr_addr     = 9'd5;
            wr_data     = 4'h7;
            swap_req    = (cnt == 10);
            frame_start = (cnt == 20);
            clear_req   = (cnt == 30);
            clear_val   = 4'h9;
            @(negedge clk);
            cnt++;
            if (swap_ack) ack_seen = 1'b1;
        end
        wr_en = 1'b0; swap_req = 1'b0; frame_start = 1'b0; clear_req = 1'b0;
        check("clear busy cycles", cnt, BANK_DEPTH);
        check("no swap while busy", ack_seen, 0);
        check("front held while busy", front_sel, 0);
        step(1'b0, 1'b1);
        check("swap after clear ack", swap_ack, 1);
        check("swap after clear front", front_sel, 1);
        do_read(9'd0, d, v);
        check("clear data @0", d, 4'h3);
        do_read(9'd5, d, v);
        check("clear data @5", d, 4'h3);
        do_read(9'd99, d, v);
        check("clear data @99", d, 4'h3);
        do_read(9'd100, d, v);
        check("clear data @100", d, 4'h3);
        do_read(9'd199, d, v);
        check("clear data @199", d, 4'h3);

        // Reset mid-clear with a read in flight and a swap pending.
        do_write(9'd300, 4'h1);
        clear_req = 1'b1; clear_val = 4'h6;
        @(negedge clk);
        clear_req = 1'b0;
        step(1'b1, 1'b0);
        repeat (8) @(negedge clk);
        rd_en = 1'b1; rd_addr = 9'd0;
        @(negedge clk);
        rd_en = 1'b0;
        check("pre-reset busy", busy, 1);
        check("pre-reset rd_valid", rd_valid, 1);
        check("pre-reset front", front_sel, 1);
        check("pre-reset oob_err", oob_err, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async rst busy", busy, 0);
        check("async rst front", front_sel, 0);
        check("async rst rd_valid", rd_valid, 0);
        check("async rst oob_err", oob_err, 0);
        check("async rst rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1'b0, 1'b1);
        check("pending discarded ack", swap_ack, 0);
        check("pending discarded front", front_sel, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/banked_frame_buffer.md
Name: banked_frame_buffer

Overview:
Parametrised, double-buffered pixel store built from N memory banks per frame; the banks are either vendor large-RAM macros or inferred RAM when SIM=1. The writer (rasteriser/SPI side) fills the back frame while the display reader scans the front frame. A swap is requested at any time and executes only on the reader's frame-start pulse. The block adds a pipelined bank-select, a hardware back-frame clear engine and out-of-range detection.

Parameters:
DATA_W, 4, bits per pixel word
ADDR_W, 18, width of pixel address ports
BANK_DEPTH, 128000, words per bank
BANK_AW, 17, bank-local address width; must satisfy 2**BANK_AW >= BANK_DEPTH
NUM_BANKS, 2, banks per frame; total physical banks = 2*NUM_BANKS
RD_LAT, 1, bank read latency in cycles (1 or 2)
SIM, 0, 1 selects inferred RAM, 0 selects vendor macro

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
wr_en  in  1  host write strobe into the back frame
wr_addr  in  ADDR_W  host write pixel address
wr_data  in  DATA_W  host write data
rd_en  in  1  read strobe from the front frame
rd_addr  in  ADDR_W  read pixel address
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data valid
swap_req  in  1  pulse: request a front/back swap
frame_start  in  1  pulse: reader vsync; swap point
swap_ack  out  1  one-cycle pulse when the swap executes
front_sel  out  1  index of the current front frame set
clear_req  in  1  pulse: fill the back frame with clear_val
clear_val  in  DATA_W  fill value, sampled on clear_req
busy  out  1  clear in progress
oob_err  out  1  sticky: an out-of-range access occurred
oob_clr  in  1  clears oob_err
ready  out  1  all banks initialised

Behaviour:
- Reset values: rd_data=0, rd_valid=0, swap_ack=0, front_sel=0, busy=0, oob_err=0, swap-pending=0, clear counter=0.
- Address decode:
  - The bank index is the highest i with addr >= i*BANK_DEPTH. Decode uses a compare chain with constant thresholds; no divider.
  - Offset = addr - i*BANK_DEPTH, truncated to BANK_AW bits.
  - in_range = addr < NUM_BANKS*BANK_DEPTH. The bank/offset boundary is exact: addr 127999 maps to bank 0 offset 127999; addr 128000 maps to bank 1 offset 0.
- Write path:
  - When wr_en & in_range & !busy, write to physical bank (~front_sel)*NUM_BANKS+i in the same cycle.
  - wr_en while busy: the write is dropped silently.
  - wr_en & !in_range: the write is dropped and oob_err is set.
- Read path:
  - On rd_en, address the front bank; unselected banks get address 0.
  - The bank index, in_range and front_sel are captured at issue and delayed RD_LAT cycles. The output mux uses the delayed select, not the live rd_addr.
  - rd_valid = rd_en delayed RD_LAT cycles. Out-of-range reads return 0 with rd_valid=1 and set oob_err.
  - A swap executing during in-flight reads does not affect them; they complete from the old front frame.
- oob_err: set has priority over oob_clr when both occur in the same cycle.
- FSM (fb_pkg::fb_state_t):
  - IDLE: clear_req -> CLEAR (latch clear_val, counter=0, busy=1).
  - CLEAR: each cycle writes clear_val at offset=counter into all NUM_BANKS back banks in parallel.
  - CLEAR: counter==BANK_DEPTH-1 -> IDLE, busy=0. A clear therefore lasts exactly BANK_DEPTH cycles.
  - clear_req while in CLEAR is ignored.
- Swap handshake:
  - swap_req sets swap-pending; a repeat swap_req while pending has no effect.
  - The swap executes on the first frame_start where pending=1 and busy=0: front_sel toggles, swap_ack pulses and pending clears, all on the clock edge after that frame_start.
  - swap_req and frame_start in the same cycle with pending=0: pending is set; the swap waits for the next frame_start.
  - frame_start with pending=0: nothing happens.
- ready: AND of all bank ready outputs. In SIM mode bank ready is tied to 1.
- Reset mid-operation: aborts any clear and discards a pending swap; all outputs return to their reset values immediately. RAM contents are undefined.

Decomposition:
- fb_pkg holds:
  - fb_state_t {IDLE, CLEAR};
  - a localparam function returning the bank threshold i*BANK_DEPTH;
  - a localparam for total banks.
- Sub-module fb_bank_decode (combinational, parametrised): addr -> bank index, offset, in_range. It is instantiated twice, once for read and once for write.
- Bank instances are built in a generate loop; the SIM switch selects between the inferred RAM and the vendor macro.

Test Plan:
- Boundary mapping: write 0xA@127999 and 0x5@128000, swap_req, frame_start, then read both -> rd_valid 1 cycle after each rd_en, data 0xA then 0x5.
- Out of range: wr_en@256000 -> no bank write, oob_err=1; rd@256000 -> rd_data=0, rd_valid=1; oob_clr -> oob_err=0.
- Swap handshake: swap_req@cycle10, second swap_req@20, frame_start@50 -> exactly one swap: front_sel toggles and swap_ack pulses @51; frame_start@80 -> no toggle.
- Clear: clear_req with clear_val=0x3 -> busy high for exactly 128000 cycles; a wr_en of 0x7@5 during busy is dropped; after swap, reads @0, @5 and @255999 all return 0x3.
- Swap deferred by clear: swap_req during busy, frame_start during busy -> no swap; next frame_start after busy falls -> swap_ack.
- Reset mid-clear: rst_n low at counter 1000 -> busy=0, front_sel=0, rd_valid=0, oob_err=0 with no clock edge required.
